// File: rtl/universal_shift_register_if.sv
// Purpose : control/data bundle of the universal shift register.
// Signals : Enable_In, Mode_In, Load_Data_In, Serial_L_In, Serial_R_In (towards the register),
//           Q_Out, Qb_Out, Serial_Msb_Out, Serial_Lsb_Out, Frame_Done_Out (from the register).
// Modports: master = the side driving operations, slave = the register itself.
interface universal_shift_register_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Enable_In;
  logic [2:0]       Mode_In;
  logic [WIDTH-1:0] Load_Data_In;
  logic             Serial_L_In;
  logic             Serial_R_In;
  logic [WIDTH-1:0] Q_Out;
  logic [WIDTH-1:0] Qb_Out;
  logic             Serial_Msb_Out;
  logic             Serial_Lsb_Out;
  logic             Frame_Done_Out;

  modport master (
    output Enable_In, Mode_In, Load_Data_In, Serial_L_In, Serial_R_In,
    input  Q_Out, Qb_Out, Serial_Msb_Out, Serial_Lsb_Out, Frame_Done_Out
  );

  modport slave (
    input  Enable_In, Mode_In, Load_Data_In, Serial_L_In, Serial_R_In,
    output Q_Out, Qb_Out, Serial_Msb_Out, Serial_Lsb_Out, Frame_Done_Out
  );
endinterface

// File: rtl/universal_shift_register.sv
// Purpose : WIDTH-bit register bank with hold, parallel load, logical shift,
//           rotate, arithmetic shift right and clear, plus a frame counter that
//           pulses Frame_Done_Out after every FRAME_LEN shift operations.
// Ports   : Clk_In   - clock, all state changes on the rising edge
//           Reset_In - synchronous active-high reset (Q=RESET_VALUE, count=0, pulse=0)
//           bus      - slave side of universal_shift_register_if (op select, load data,
//                      serial inputs, Q/Qb, serial taps, frame pulse)
module universal_shift_register #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      FRAME_LEN   = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                        Clk_In,
  input logic                        Reset_In,
  universal_shift_register_if.slave  bus
);

  localparam int unsigned CNT_W_RAW = $clog2(FRAME_LEN + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;

  logic [WIDTH-1:0] shl_val, shr_val, rotl_val, rotr_val, asr_val;
  logic [WIDTH-1:0] shift_val;
  logic             shift_op;

  // Shift results built on a WIDTH+1 vector and truncated, so WIDTH=1 needs no special case:
  // the widened vector always has a bit to drop and the serial/feedback bit lands in place.
  assign shl_val  = WIDTH'({q_q, bus.Serial_L_In});
  assign shr_val  = WIDTH'({bus.Serial_R_In, q_q} >> 1);
  assign rotl_val = WIDTH'({q_q, q_q[WIDTH-1]});
  assign rotr_val = WIDTH'({q_q[0], q_q} >> 1);
  assign asr_val  = WIDTH'({q_q[WIDTH-1], q_q} >> 1);

  // Next-state decode for register contents, frame counter and frame pulse.
  always_comb begin
    q_d          = q_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    shift_val    = q_q;
    shift_op     = 1'b0;

    if (bus.Enable_In) begin
      case (bus.Mode_In)
        MODE_HOLD: ;
        MODE_LOAD: begin
          q_d   = bus.Load_Data_In;
          cnt_d = '0;
        end
        MODE_SHL: begin
          shift_val = shl_val;
          shift_op  = 1'b1;
        end
        MODE_SHR: begin
          shift_val = shr_val;
          shift_op  = 1'b1;
        end
        MODE_ROTL: begin
          shift_val = rotl_val;
          shift_op  = 1'b1;
        end
        MODE_ROTR: begin
          shift_val = rotr_val;
          shift_op  = 1'b1;
        end
        MODE_ASR: begin
          shift_val = asr_val;
          shift_op  = 1'b1;
        end
        MODE_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end

    // Every shift-class op advances the frame; the last one of a frame wraps and pulses.
    if (shift_op) begin
      q_d = shift_val;
      if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      q_q          <= RESET_VALUE;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Serial taps and complement are plain views of the stored value.
  assign bus.Q_Out          = q_q;
  assign bus.Qb_Out         = ~q_q;
  assign bus.Serial_Msb_Out = q_q[WIDTH-1];
  assign bus.Serial_Lsb_Out = q_q[0];
  assign bus.Frame_Done_Out = frame_done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  localparam int unsigned W       = 8;
  localparam int unsigned FLEN    = 8;
  localparam logic [7:0]  RV      = 8'hA5;
  localparam int          MODV    = 256;
  localparam int          HALF    = 128;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ROTL = 3'd4;
  localparam logic [2:0] M_ROTR = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;
  localparam logic [2:0] M_CLR  = 3'd7;

  logic clk;
  logic rst;

  universal_shift_register_if #(.WIDTH(8)) bus8 ();
  universal_shift_register_if #(.WIDTH(1)) bus1 ();

  universal_shift_register #(.WIDTH(8), .FRAME_LEN(8), .RESET_VALUE(8'hA5)) dut (
    .Clk_In   (clk),
    .Reset_In (rst),
    .bus      (bus8.slave)
  );

  // Degenerate corner: one bit wide, one-op frames.
  universal_shift_register #(.WIDTH(1), .FRAME_LEN(1), .RESET_VALUE(1'b1)) dut1 (
    .Clk_In   (clk),
    .Reset_In (rst),
    .bus      (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: integer value plus a count of shift ops in the current frame.
  int m_q, m_cnt;
  bit m_done;
  int m1_q;
  bit m1_done;

  // One clock: drive inputs mid-cycle, advance the model at the edge, sample 1 time unit later.
  task automatic step(input bit r, input bit en, input logic [2:0] mode,
                      input logic [7:0] ld, input bit sl, input bit sr);
    bit is_shift;
    @(negedge clk);
    rst                = r;
    bus8.Enable_In     = en;
    bus8.Mode_In       = mode;
    bus8.Load_Data_In  = ld;
    bus8.Serial_L_In   = sl;
    bus8.Serial_R_In   = sr;
    bus1.Enable_In     = en;
    bus1.Mode_In       = mode;
    bus1.Load_Data_In  = ld[0];
    bus1.Serial_L_In   = sl;
    bus1.Serial_R_In   = sr;
    @(posedge clk);
    is_shift = en && (mode >= M_SHL) && (mode <= M_ASR);
    if (r) begin
      m_q = int'(RV); m_cnt = 0; m_done = 0;
      m1_q = 1; m1_done = 0;
    end else begin
      m_done  = 0;
      m1_done = is_shift;
      if (en) begin
        case (mode)
          M_LOAD: begin m_q = int'(ld); m_cnt = 0; m1_q = int'(ld[0]); end
          M_SHL:  begin m_q = (m_q * 2 + int'(sl)) % MODV; m1_q = int'(sl); end
          M_SHR:  begin m_q = int'(sr) * HALF + m_q / 2; m1_q = int'(sr); end
          M_ROTL: m_q = (m_q * 2) % MODV + m_q / HALF;
          M_ROTR: m_q = (m_q % 2) * HALF + m_q / 2;
          M_ASR:  m_q = m_q / 2 + ((m_q >= HALF) ? HALF : 0);
          M_CLR:  begin m_q = 0; m_cnt = 0; m1_q = 0; end
          default: ;
        endcase
        if (is_shift) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == int'(FLEN)) begin
            m_cnt  = 0;
            m_done = 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, M_HOLD, 8'h00, 0, 0);
    n_run++;
    if (bus8.Q_Out !== 8'hA5) begin
      n_fail++; $display("FAIL reset_q: got %h expected a5", bus8.Q_Out);
    end
    n_run++;
    if (bus8.Qb_Out !== 8'h5A) begin
      n_fail++; $display("FAIL reset_qb: got %h expected 5a", bus8.Qb_Out);
    end
    n_run++;
    if (bus8.Frame_Done_Out !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", bus8.Frame_Done_Out);
    end
    step(0, 1, M_LOAD, 8'h3C, 0, 0);
    step(1, 1, M_LOAD, 8'hFF, 0, 0);
    n_run++;
    if (bus8.Q_Out !== 8'hA5) begin
      n_fail++; $display("FAIL reset_over_load: got %h expected a5", bus8.Q_Out);
    end
  endtask

  task automatic test_load_shift();
    step(0, 1, M_LOAD, 8'h81, 0, 0);
    n_run++;
    if (bus8.Q_Out !== 8'h81) begin
      n_fail++; $display("FAIL load: got %h expected 81", bus8.Q_Out);
    end
    step(0, 1, M_SHL, 8'h00, 1, 0);
    n_run++;
    if (bus8.Q_Out !== 8'h03) begin
      n_fail++; $display("FAIL shl: got %h expected 03", bus8.Q_Out);
    end
    step(0, 1, M_SHR, 8'h00, 1, 0);
    n_run++;
    if (bus8.Q_Out !== 8'h01) begin
      n_fail++; $display("FAIL shr: got %h expected 01", bus8.Q_Out);
    end
    step(0, 1, M_LOAD, 8'h80, 0, 0);
    step(0, 1, M_ASR, 8'h00, 0, 0);
    n_run++;
    if (bus8.Q_Out !== 8'hC0) begin
      n_fail++; $display("FAIL asr: got %h expected c0", bus8.Q_Out);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_seq [3];
    logic [2:0] mode_seq [3];
    exp_seq  = '{8'h03, 8'h81, 8'hC0};
    mode_seq = '{M_ROTL, M_ROTR, M_ROTR};
    step(0, 1, M_LOAD, 8'h81, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, mode_seq[i], 8'h00, 1, 1);
      n_run++;
      if (bus8.Q_Out !== exp_seq[i]) begin
        n_fail++; $display("FAIL rot_%0d: got %h expected %h", i, bus8.Q_Out, exp_seq[i]);
      end
      n_run++;
      if ({bus8.Serial_Msb_Out, bus8.Serial_Lsb_Out} !== {exp_seq[i][7], exp_seq[i][0]}) begin
        n_fail++; $display("FAIL rot_taps_%0d: got %b%b expected %b%b", i, bus8.Serial_Msb_Out,
                           bus8.Serial_Lsb_Out, exp_seq[i][7], exp_seq[i][0]);
      end
    end
  endtask

  task automatic test_frame_pulse();
    int pulses [$];
    step(0, 1, M_LOAD, 8'h00, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, M_SHL, 8'h00, 1, 0);
      if (bus8.Frame_Done_Out === 1'b1) pulses.push_back(i);
    end
    n_run++;
    if (pulses.size() != 2 || pulses[0] != 8 || pulses[1] != 16) begin
      n_fail++; $display("FAIL frame_pulses: got %0d pulses (first at %0d) expected 2 at 8,16",
                         pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
    end
    step(0, 1, M_HOLD, 8'h00, 0, 0);
    n_run++;
    if (bus8.Frame_Done_Out !== 1'b0) begin
      n_fail++; $display("FAIL frame_single_cycle: got %b expected 0", bus8.Frame_Done_Out);
    end
  endtask

  task automatic test_frame_restart();
    int npulse;
    logic [7:0] frozen;
    step(0, 1, M_LOAD, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, M_SHL, 8'h00, 1, 0);
    step(0, 1, M_LOAD, 8'h00, 0, 0);
    npulse = 0;
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, M_SHL, 8'h00, 0, 0);
      if (bus8.Frame_Done_Out === 1'b1) npulse += (i == 8) ? 1 : 100;
    end
    n_run++;
    if (npulse != 1) begin
      n_fail++; $display("FAIL restart_load: pulse score %0d expected 1", npulse);
    end
    step(0, 1, M_LOAD, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, M_SHL, 8'h00, 1, 0);
    frozen = bus8.Q_Out;
    npulse = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, M_SHL, 8'hFF, 1, 1);
      if (bus8.Frame_Done_Out === 1'b1) npulse++;
    end
    n_run++;
    if (frozen !== 8'h07 || bus8.Q_Out !== 8'h07 || npulse != 0) begin
      n_fail++; $display("FAIL disable_hold: got q %h/%h pulses %0d expected 07/07 0",
                         frozen, bus8.Q_Out, npulse);
    end
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, M_SHL, 8'h00, 0, 0);
      if (bus8.Frame_Done_Out === 1'b1) npulse += (i == 5) ? 1 : 100;
    end
    n_run++;
    if (npulse != 1) begin
      n_fail++; $display("FAIL hold_resume_pulse: pulse score %0d expected 1", npulse);
    end
  endtask

  task automatic test_mid_reset_clear();
    int npulse;
    step(0, 1, M_LOAD, 8'h00, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, M_SHL, 8'h00, 1, 0);
    step(1, 1, M_SHL, 8'h00, 1, 0);
    npulse = 0;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, M_SHL, 8'h00, 1, 0);
      if (bus8.Frame_Done_Out === 1'b1) npulse++;
    end
    n_run++;
    if (npulse != 0) begin
      n_fail++; $display("FAIL mid_reset_nopulse: got %0d pulses expected 0", npulse);
    end
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, M_SHL, 8'h00, 1, 0);
      if (bus8.Frame_Done_Out === 1'b1) npulse += (i == 6) ? 1 : 100;
    end
    n_run++;
    if (npulse != 1) begin
      n_fail++; $display("FAIL mid_reset_pulse: pulse score %0d expected 1", npulse);
    end
    step(0, 1, M_CLR, 8'hFF, 1, 1);
    n_run++;
    if (bus8.Q_Out !== 8'h00) begin
      n_fail++; $display("FAIL clr: got %h expected 00", bus8.Q_Out);
    end
  endtask

  task automatic test_random();
    bit r, en, sl, sr;
    logic [2:0] mode;
    logic [7:0] ld;
    step(1, 0, M_HOLD, 8'h00, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r    = ($urandom_range(0, 29) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = 3'($urandom_range(0, 7));
      ld   = 8'($urandom);
      sl   = 1'($urandom);
      sr   = 1'($urandom);
      step(r, en, mode, ld, sl, sr);
      n_run++;
      if (bus8.Q_Out !== 8'(m_q) || bus8.Qb_Out !== ~8'(m_q) ||
          bus8.Frame_Done_Out !== m_done ||
          bus8.Serial_Msb_Out !== bus8.Q_Out[7] || bus8.Serial_Lsb_Out !== bus8.Q_Out[0]) begin
        n_fail++;
        $display("FAIL rand8_%0d: got q %h qb %h done %b taps %b%b expected q %h done %b",
                 i, bus8.Q_Out, bus8.Qb_Out, bus8.Frame_Done_Out, bus8.Serial_Msb_Out,
                 bus8.Serial_Lsb_Out, 8'(m_q), m_done);
      end
      n_run++;
      if (bus1.Q_Out !== 1'(m1_q) || bus1.Qb_Out !== ~1'(m1_q) ||
          bus1.Frame_Done_Out !== m1_done ||
          bus1.Serial_Msb_Out !== 1'(m1_q) || bus1.Serial_Lsb_Out !== 1'(m1_q)) begin
        n_fail++;
        $display("FAIL rand1_%0d: got q %b done %b expected q %b done %b",
                 i, bus1.Q_Out, bus1.Frame_Done_Out, 1'(m1_q), m1_done);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.Enable_In = 0; bus8.Mode_In = M_HOLD; bus8.Load_Data_In = '0;
    bus8.Serial_L_In = 0; bus8.Serial_R_In = 0;
    bus1.Enable_In = 0; bus1.Mode_In = M_HOLD; bus1.Load_Data_In = '0;
    bus1.Serial_L_In = 0; bus1.Serial_R_In = 0;
    m_q = 0; m_cnt = 0; m_done = 0; m1_q = 0; m1_done = 0;
    test_reset();
    test_load_shift();
    test_rotation();
    test_frame_pulse();
    test_frame_restart();
    test_mid_reset_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
